instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 16 +
 rtl/instr_loader_encoder.sv | 53 +++++
 rtl/instr_loader.sv | 146 ++++++++++++++
 tb/tb_instr_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader and the decode side.
// - state_t     : loader FSM state encoding
// - BRANCH_BIT  : op1 bit that marks a branch-class instruction
// - REG_FIELD_W : width of each register slot in the encoded word
package instr_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int BRANCH_BIT  = 2;
    localparam int REG_FIELD_W = 4;

endpackage

// File: rtl/instr_loader_encoder.sv
// instr_encoder: purely combinational packing of one instruction field set.
// Layout (32-bit word, resized to INSTR_WIDTH):
//   [31:28] op1, [27:24] op2
//   branch     (op1[BRANCH_BIT]=1): [23:20] rs1, [19:16] rs2, [15:0] imm16
//   non-branch (op1[BRANCH_BIT]=0): [23:20] rd,  [19:16] rs1,
//                                   [15:0] imm16 if use_imm else {rs2, 12'b0}
// Ports: op1/op2 opcode nibbles, rd/rs1/rs2 register fields, imm16, use_imm,
//        instr encoded output.
module instr_encoder
    import instr_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_WIDTH   = 4
)
(
    input  logic [3:0]             op1,
    input  logic [3:0]             op2,
    input  logic [REG_WIDTH-1:0]   rd,
    input  logic [REG_WIDTH-1:0]   rs1,
    input  logic [REG_WIDTH-1:0]   rs2,
    input  logic [15:0]            imm16,
    input  logic                   use_imm,
    output logic [INSTR_WIDTH-1:0] instr
);

    // Register slots in the word are fixed at four bits regardless of REG_WIDTH.
    logic [REG_FIELD_W-1:0] rd_f;
    logic [REG_FIELD_W-1:0] rs1_f;
    logic [REG_FIELD_W-1:0] rs2_f;
    logic [31:0]            word;

    assign rd_f  = REG_FIELD_W'(rd);
    assign rs1_f = REG_FIELD_W'(rs1);
    assign rs2_f = REG_FIELD_W'(rs2);

    always_comb begin
        word        = '0;
        word[31:28] = op1;
        word[27:24] = op2;
        if (op1[BRANCH_BIT]) begin
            word[23:20] = rs1_f;
            word[19:16] = rs2_f;
            word[15:0]  = imm16;
        end else begin
            word[23:20] = rd_f;
            word[19:16] = rs1_f;
            word[15:0]  = use_imm ? imm16 : {rs2_f, 12'b0};
        end
    end

    assign instr = INSTR_WIDTH'(word);

endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts instruction field sets over a valid/ready handshake
// during a load session and writes the encoded words into instruction memory
// at consecutive (wrapping) addresses, one cycle after each transfer.
// Ports:
//   clk, reset (async, active-high)
//   start, base_addr, max_count : session launch, sampled in IDLE
//   in_valid/in_ready, op1, op2, rd, rs1, rs2, imm16, use_imm, in_last : field input
//   imem_we, imem_addr, imem_wdata : registered memory write port
//   busy, done, word_count          : session status
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_WIDTH   = 4,
    parameter int ADDR_WIDTH  = 10
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  max_count,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             op1,
    input  logic [3:0]             op2,
    input  logic [REG_WIDTH-1:0]   rd,
    input  logic [REG_WIDTH-1:0]   rs1,
    input  logic [REG_WIDTH-1:0]   rs2,
    input  logic [15:0]            imm16,
    input  logic                   use_imm,
    input  logic                   in_last,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  word_count
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                 state_reg;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  addr_reg;      // address for the next transfer
    logic [ADDR_WIDTH-1:0]  max_reg;
    logic [ADDR_WIDTH-1:0]  count_reg;
    logic [ADDR_WIDTH-1:0]  count_next_val;
    logic [ADDR_WIDTH-1:0]  waddr_reg;
    logic [INSTR_WIDTH-1:0] wdata_reg;
    logic [INSTR_WIDTH-1:0] enc_word;
    logic                   we_reg;
    logic                   xfer;
    logic                   start_ok;

    instr_encoder #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .REG_WIDTH   (REG_WIDTH)
    ) u_encoder (
        .op1     (op1),
        .op2     (op2),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm16   (imm16),
        .use_imm (use_imm),
        .instr   (enc_word)
    );

    assign count_next_val = count_reg + ONE;
    assign start_ok       = (state_reg == ST_IDLE) && start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake/status outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        xfer       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    // A zero-length session completes without accepting anything.
                    state_next = (max_count == '0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                xfer     = in_valid;
                if (in_valid && (in_last || (count_next_val == max_reg))) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Session counters and the registered memory write port. Address and data
    // only change on a transfer, so they hold while imem_we is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg  <= '0;
            max_reg   <= '0;
            count_reg <= '0;
            waddr_reg <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
        end else begin
            we_reg <= xfer;
            if (start_ok) begin
                addr_reg  <= base_addr;
                max_reg   <= max_count;
                count_reg <= '0;
            end
            if (xfer) begin
                waddr_reg <= addr_reg;
                wdata_reg <= enc_word;
                addr_reg  <= addr_reg + ONE;   // wraps naturally at all-ones
                count_reg <= count_next_val;
            end
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = waddr_reg;
    assign imem_wdata = wdata_reg;
    assign word_count = count_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader: linear stimulus with hand-computed
// expected words, addresses and status flags.
module tb_instr_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  max_count;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op1, op2, rd, rs1, rs2;
    logic [15:0] imm16;
    logic        use_imm;
    logic        in_last;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [9:0]  word_count;

    int checks = 0;
    int errors = 0;

    instr_loader #(
        .INSTR_WIDTH (32),
        .REG_WIDTH   (4),
        .ADDR_WIDTH  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .max_count  (max_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op1        (op1),
        .op2        (op2),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm16      (imm16),
        .use_imm    (use_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (imem_we)
            $display("write addr %h data %h count %0d", imem_addr, imem_wdata, word_count);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic we, input logic [9:0] addr,
                              input logic [31:0] data, input logic rdy, input logic bsy,
                              input logic dn, input logic [9:0] wc);
        check({tag, ".we"},    32'(imem_we),    32'(we));
        check({tag, ".addr"},  32'(imem_addr),  32'(addr));
        check({tag, ".wdata"}, imem_wdata,      data);
        check({tag, ".ready"}, 32'(in_ready),   32'(rdy));
        check({tag, ".busy"},  32'(busy),       32'(bsy));
        check({tag, ".done"},  32'(done),       32'(dn));
        check({tag, ".count"}, 32'(word_count), 32'(wc));
    endtask

    task automatic fields(input logic [3:0] o1, input logic [3:0] o2, input logic [3:0] d,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] im,
                          input logic ui, input logic last);
        op1 = o1; op2 = o2; rd = d; rs1 = s1; rs2 = s2;
        imm16 = im; use_imm = ui; in_last = last;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; max_count = '0; in_valid = 1'b0;
        fields(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0);
        step(); step();
        check_outs("reset", 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0);
        reset = 1'b0;
        step();
        check_outs("idle", 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0);

        // Session A: wrap-around addressing, terminated by max_count=4.
        base_addr = 10'h3FE; max_count = 10'd4; start = 1'b1;
        step();
        start = 1'b0; base_addr = '0; max_count = '0;
        check_outs("a_load", 1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 1'b0, 10'd0);
        in_valid = 1'b1;
        fields(4'h0, 4'h1, 4'd3, 4'd5, 4'd0, 16'hBEEF, 1'b1, 1'b0);
        step();
        check_outs("a_w0", 1'b1, 10'h3FE, 32'h0135BEEF, 1'b1, 1'b1, 1'b0, 10'd1);
        // Branch class: rd dropped, rs1/rs2 in the upper register slots.
        fields(4'h4, 4'hA, 4'd9, 4'd2, 4'd7, 16'h0010, 1'b1, 1'b0);
        step();
        check_outs("a_w1", 1'b1, 10'h3FF, 32'h4A270010, 1'b1, 1'b1, 1'b0, 10'd2);
        // Non-branch with rs2 in the low half.
        fields(4'h1, 4'h2, 4'd6, 4'd7, 4'hC, 16'hFFFF, 1'b0, 1'b0);
        step();
        check_outs("a_w2", 1'b1, 10'h000, 32'h1267C000, 1'b1, 1'b1, 1'b0, 10'd3);
        fields(4'hF, 4'h0, 4'd1, 4'hA, 4'hB, 16'h1234, 1'b0, 1'b0);
        step();
        check_outs("a_w3", 1'b1, 10'h001, 32'hF0AB1234, 1'b0, 1'b1, 1'b1, 10'd4);
        step();
        check_outs("a_end", 1'b0, 10'h001, 32'hF0AB1234, 1'b0, 1'b0, 1'b0, 10'd4);
        in_valid = 1'b0;
        step();
        check_outs("a_idle", 1'b0, 10'h001, 32'hF0AB1234, 1'b0, 1'b0, 1'b0, 10'd4);

        // Session B: in_last on third transfer; start during LOAD is ignored.
        base_addr = 10'h100; max_count = 10'd8; start = 1'b1;
        step();
        start = 1'b0;
        check_outs("b_load", 1'b0, 10'h001, 32'hF0AB1234, 1'b1, 1'b1, 1'b0, 10'd0);
        in_valid = 1'b1; start = 1'b1; base_addr = 10'h200; max_count = 10'd1;
        fields(4'h2, 4'h3, 4'd1, 4'd2, 4'd0, 16'h00AA, 1'b1, 1'b0);
        step();
        start = 1'b0;
        check_outs("b_w0", 1'b1, 10'h100, 32'h231200AA, 1'b1, 1'b1, 1'b0, 10'd1);
        fields(4'h6, 4'h5, 4'd8, 4'd3, 4'd4, 16'hC0DE, 1'b0, 1'b0);
        step();
        check_outs("b_w1", 1'b1, 10'h101, 32'h6534C0DE, 1'b1, 1'b1, 1'b0, 10'd2);
        in_valid = 1'b0;
        step();
        check_outs("b_gap", 1'b0, 10'h101, 32'h6534C0DE, 1'b1, 1'b1, 1'b0, 10'd2);
        in_valid = 1'b1;
        fields(4'h8, 4'h9, 4'hE, 4'hD, 4'd5, 16'h1111, 1'b0, 1'b1);
        step();
        check_outs("b_w2", 1'b1, 10'h102, 32'h89ED5000, 1'b0, 1'b1, 1'b1, 10'd3);
        step();
        check_outs("b_end", 1'b0, 10'h102, 32'h89ED5000, 1'b0, 1'b0, 1'b0, 10'd3);
        in_valid = 1'b0; in_last = 1'b0;

        // Session C: zero-length session, valid held high throughout.
        in_valid = 1'b1; base_addr = 10'h080; max_count = 10'd0; start = 1'b1;
        step();
        start = 1'b0;
        check_outs("c_fin", 1'b0, 10'h102, 32'h89ED5000, 1'b0, 1'b1, 1'b1, 10'd0);
        step();
        check_outs("c_idle", 1'b0, 10'h102, 32'h89ED5000, 1'b0, 1'b0, 1'b0, 10'd0);
        in_valid = 1'b0;

        // Session D: reset while a further transfer is being presented.
        base_addr = 10'h050; max_count = 10'd4; start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        fields(4'h0, 4'h0, 4'd1, 4'd1, 4'd0, 16'h0001, 1'b1, 1'b0);
        step();
        check_outs("d_w0", 1'b1, 10'h050, 32'h00110001, 1'b1, 1'b1, 1'b0, 10'd1);
        fields(4'h3, 4'h3, 4'd2, 4'd2, 4'd0, 16'h0002, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_outs("d_rst", 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0);
        step();
        check_outs("d_rst_hold", 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0);
        reset = 1'b0;
        step();
        check_outs("d_rel", 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0);
        step();
        check_outs("d_rel2", 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 10'd0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
